// File: rtl/afe_spi_master.sv
// Byte-sequenced SPI mode-0 master for the AFE4403 register port (4-byte frames, MSB first).
// Define AFE_SPI_WORD_OUT_EN to add rd_word/rd_word_vld (24-bit read data of a read frame).
module afe_spi_master #(
    parameter int unsigned SCLK_HALF  = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       div_clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] tx_data,
    output logic [1:0] data_part,
    output logic       flash,
    output logic       spi_done,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_ste,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
`ifdef AFE_SPI_WORD_OUT_EN
    ,
    output logic [23:0] rd_word,
    output logic        rd_word_vld
`endif
);

    localparam int unsigned HalfW = $clog2(SCLK_HALF) + 1;
    localparam int unsigned GapW  = $clog2(GAP_CYCLES) + 1;
    localparam logic [HalfW-1:0] HalfLast = HalfW'(SCLK_HALF - 1);
    localparam logic [HalfW-1:0] HalfOne  = HalfW'(1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);
    localparam logic [GapW-1:0]  GapOne   = GapW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StLoad,
        StShift,
        StDone,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       part_q, part_d;
    logic             rd_mode_q, rd_mode_d;
    logic [6:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [HalfW-1:0] half_cnt_q, half_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic             ste_q, ste_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic [7:0]       load_byte;
    logic             req;

    assign req = wr_en | rd_en;

    always_comb begin
        state_d    = state_q;
        part_d     = part_q;
        rd_mode_d  = rd_mode_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ste_d      = ste_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        // Read frames clock zeros out on the data bytes.
        load_byte  = (rd_mode_q && (part_q != 2'd0)) ? 8'h00 : tx_data;

        unique case (state_q)
            StIdle: begin
                part_d = 2'd0;
                if (req) begin
                    state_d   = StPrep;
                    rd_mode_d = ~wr_en;
                    ste_d     = 1'b0;
                end
            end
            StPrep: begin
                state_d = StLoad;
            end
            StLoad: begin
                tx_sr_d    = load_byte[6:0];
                mosi_d     = load_byte[7];
                half_cnt_d = '0;
                bit_cnt_d  = 3'd0;
                sclk_d     = 1'b0;
                state_d    = StShift;
            end
            StShift: begin
                if (half_cnt_q == HalfLast) begin
                    half_cnt_d = '0;
                    sclk_d     = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sr_d = {rx_sr_q[6:0], spi_miso};
                    end else begin
                        // Falling edge: next MOSI bit, or end of byte after bit 0.
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[5:0], 1'b0};
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d = rx_sr_q;
                            state_d   = StDone;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HalfOne;
                end
            end
            StDone: begin
                if (part_q != 2'd3) begin
                    part_d  = part_q + 2'd1;
                    state_d = StPrep;
                end else begin
                    part_d    = 2'd0;
                    ste_d     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                // The last gap cycle doubles as the idle decision, so a held request
                // sees STE high for exactly GAP_CYCLES.
                if (gap_cnt_q == GapLast) begin
                    if (req) begin
                        state_d   = StPrep;
                        rd_mode_d = ~wr_en;
                        ste_d     = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GapOne;
                end
            end
            default: begin
                state_d = StIdle;
                ste_d   = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            part_q     <= 2'd0;
            rd_mode_q  <= 1'b0;
            tx_sr_q    <= 7'd0;
            rx_sr_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            half_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            gap_cnt_q  <= '0;
            ste_q      <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            part_q     <= part_d;
            rd_mode_q  <= rd_mode_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ste_q      <= ste_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign data_part = part_q;
    assign flash     = (state_q == StPrep);
    assign spi_done  = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign rx_data   = rx_data_q;
    assign spi_ste   = ste_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;

`ifdef AFE_SPI_WORD_OUT_EN
    logic [15:0] word_acc_q;
    logic [23:0] rd_word_q;
    logic        rd_word_vld_q;

    // word_acc keeps the last two completed bytes; at part 3 they are H and M.
    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            word_acc_q    <= 16'd0;
            rd_word_q     <= 24'd0;
            rd_word_vld_q <= 1'b0;
        end else begin
            rd_word_vld_q <= 1'b0;
            if (state_q == StDone) begin
                word_acc_q <= {word_acc_q[7:0], rx_data_q};
                if ((part_q == 2'd3) && rd_mode_q) begin
                    rd_word_q     <= {word_acc_q, rx_data_q};
                    rd_word_vld_q <= 1'b1;
                end
            end
        end
    end

    assign rd_word     = rd_word_q;
    assign rd_word_vld = rd_word_vld_q;
`endif

endmodule

// File: tb/tb_afe_spi_master.sv
// Self-checking bench for afe_spi_master: random frames against a frame-level reference model.
module tb_afe_spi_master;

    localparam int SCLK_HALF  = 2;
    localparam int GAP_CYCLES = 2;
    localparam int FRAME_CYC  = 4 * (3 + 16 * SCLK_HALF);

    logic       div_clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] tx_data;
    logic [1:0] data_part;
    logic       flash;
    logic       spi_done;
    logic [7:0] rx_data;
    logic       busy;
    logic       spi_ste;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
`ifdef AFE_SPI_WORD_OUT_EN
    logic [23:0] rd_word;
    logic        rd_word_vld;
`endif

    int errors;
    int checks;

    afe_spi_master #(
        .SCLK_HALF (SCLK_HALF),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .div_clk  (div_clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .tx_data  (tx_data),
        .data_part(data_part),
        .flash    (flash),
        .spi_done (spi_done),
        .rx_data  (rx_data),
        .busy     (busy),
        .spi_ste  (spi_ste),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
`ifdef AFE_SPI_WORD_OUT_EN
        ,
        .rd_word    (rd_word),
        .rd_word_vld(rd_word_vld)
`endif
    );

    initial div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    // Drives one frame from the current negedge through DONE of part 3, plays the SPI slave,
    // and checks the frame against the expected MOSI stream and MISO bytes.
    task automatic run_frame(input bit exp_read, input logic [31:0] tx_word,
                             input logic [31:0] slave_word, input bit drop_at_done0);
        logic [7:0]  txb [4];
        logic [7:0]  rxb [4];
        logic [31:0] exp_mosi;
        logic [31:0] mosi_cap;
        logic [31:0] sl_sr;
        logic        prev_sclk;
        bit          restore;
        int          flash_cnt;
        int          done_cnt;
        int          ste_low;
        int          cyc;
`ifdef AFE_SPI_WORD_OUT_EN
        int          vld_seen;
        vld_seen = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            txb[i] = tx_word[31 - 8 * i -: 8];
            rxb[i] = slave_word[31 - 8 * i -: 8];
        end
        exp_mosi  = exp_read ? {tx_word[31:24], 24'h000000} : tx_word;
        mosi_cap  = 32'd0;
        sl_sr     = slave_word;
        spi_miso  = sl_sr[31];
        prev_sclk = spi_sclk;
        restore   = 1'b0;
        flash_cnt = 0;
        done_cnt  = 0;
        ste_low   = 0;
        cyc       = 0;
        while (done_cnt < 4 && cyc < 2000) begin
            if (restore) begin
                wr_en   = 1'b1;
                restore = 1'b0;
            end
            if (!spi_ste) ste_low++;
            if (flash) begin
                checks++;
                if (data_part !== 2'(flash_cnt) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL flash_part got part=%0d busy=%b exp part=%0d busy=1",
                             data_part, busy, flash_cnt);
                end
                tx_data = txb[flash_cnt[1:0]];
                flash_cnt++;
            end
            if (!prev_sclk && spi_sclk) mosi_cap = {mosi_cap[30:0], spi_mosi};
            if (prev_sclk && !spi_sclk) begin
                sl_sr    = {sl_sr[30:0], 1'b0};
                spi_miso = sl_sr[31];
            end
            prev_sclk = spi_sclk;
`ifdef AFE_SPI_WORD_OUT_EN
            if (rd_word_vld) vld_seen++;
`endif
            if (spi_done) begin
                checks++;
                if (data_part !== 2'(done_cnt) || rx_data !== rxb[done_cnt[1:0]]) begin
                    errors++;
                    $display("FAIL done_byte got part=%0d rx=%h exp part=%0d rx=%h",
                             data_part, rx_data, done_cnt, rxb[done_cnt[1:0]]);
                end
                if (drop_at_done0 && done_cnt == 0) begin
                    wr_en   = 1'b0;
                    restore = 1'b1;
                end
                done_cnt++;
            end
            if (done_cnt < 4) begin
                @(negedge div_clk);
                cyc++;
            end
        end
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL frame_timeout got done=%0d exp 4 within 2000 cycles", done_cnt);
        end
        checks++;
        if (flash_cnt !== 4) begin
            errors++;
            $display("FAIL flash_count got %0d exp 4", flash_cnt);
        end
        checks++;
        if (mosi_cap !== exp_mosi) begin
            errors++;
            $display("FAIL mosi_stream got %h exp %h", mosi_cap, exp_mosi);
        end
        checks++;
        if (ste_low !== FRAME_CYC) begin
            errors++;
            $display("FAIL ste_low_cycles got %0d exp %0d", ste_low, FRAME_CYC);
        end
        @(negedge div_clk);
        checks++;
        if (spi_ste !== 1'b1 || busy !== 1'b1 || data_part !== 2'd0) begin
            errors++;
            $display("FAIL gap_entry got ste=%b busy=%b part=%0d exp ste=1 busy=1 part=0",
                     spi_ste, busy, data_part);
        end
`ifdef AFE_SPI_WORD_OUT_EN
        checks++;
        if (vld_seen !== 0 || rd_word_vld !== exp_read) begin
            errors++;
            $display("FAIL word_vld got early=%0d vld=%b exp early=0 vld=%b",
                     vld_seen, rd_word_vld, exp_read);
        end
        if (exp_read) begin
            checks++;
            if (rd_word !== slave_word[23:0]) begin
                errors++;
                $display("FAIL rd_word got %h exp %h", rd_word, slave_word[23:0]);
            end
        end
`endif
    endtask

    task automatic finish_frame();
        int cnt;
        wr_en = 1'b0;
        rd_en = 1'b0;
        cnt   = 0;
        while (busy && cnt < 50) begin
            @(negedge div_clk);
            cnt++;
        end
        checks++;
        if (busy !== 1'b0 || spi_ste !== 1'b1 || cnt !== GAP_CYCLES) begin
            errors++;
            $display("FAIL return_idle got busy=%b ste=%b gap=%0d exp busy=0 ste=1 gap=%0d",
                     busy, spi_ste, cnt, GAP_CYCLES);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge div_clk);
        checks++;
        if (data_part !== 2'd0 || flash !== 1'b0 || spi_done !== 1'b0 || rx_data !== 8'h00 ||
            busy !== 1'b0 || spi_ste !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got part=%0d fl=%b dn=%b rx=%h busy=%b ste=%b sclk=%b mosi=%b",
                     data_part, flash, spi_done, rx_data, busy, spi_ste, spi_sclk, spi_mosi);
        end
`ifdef AFE_SPI_WORD_OUT_EN
        checks++;
        if (rd_word !== 24'h0 || rd_word_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_word got %h/%b exp 000000/0", rd_word, rd_word_vld);
        end
`endif
        rst = 1'b0;
        repeat (3) @(negedge div_clk);
        checks++;
        if (busy !== 1'b0 || spi_ste !== 1'b1) begin
            errors++;
            $display("FAIL idle_no_req got busy=%b ste=%b exp 0/1", busy, spi_ste);
        end
    endtask

    task automatic test_write();
        logic [31:0] tx;
        wr_en = 1'b1;
        run_frame(1'b0, 32'h00000005, $urandom, 1'b0);
        finish_frame();
        for (int n = 0; n < 3; n++) begin
            tx    = $urandom;
            wr_en = 1'b1;
            run_frame(1'b0, tx, $urandom, 1'b0);
            finish_frame();
        end
    endtask

    task automatic test_read();
        logic [31:0] sl;
        rd_en = 1'b1;
        run_frame(1'b1, 32'h305A5A5A, 32'h00ABCDEF, 1'b0);
        finish_frame();
        for (int n = 0; n < 3; n++) begin
            sl    = $urandom;
            rd_en = 1'b1;
            run_frame(1'b1, $urandom, sl, 1'b0);
            finish_frame();
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        wr_en = 1'b1;
        rd_en = 1'b1;
        run_frame(1'b0, $urandom, $urandom, 1'b0);
        cnt = 0;
        while (spi_ste && cnt < 50) begin
            @(negedge div_clk);
            cnt++;
        end
        checks++;
        if (cnt !== GAP_CYCLES || flash !== 1'b1) begin
            errors++;
            $display("FAIL held_gap got gap=%0d flash=%b exp gap=%0d flash=1",
                     cnt, flash, GAP_CYCLES);
        end
        run_frame(1'b0, $urandom, $urandom, 1'b0);
        finish_frame();
    endtask

    task automatic test_drop_midframe();
        wr_en = 1'b1;
        run_frame(1'b0, $urandom, $urandom, 1'b1);
        finish_frame();
    endtask

    task automatic test_rst_midframe();
        int cnt;
        int dones;
        rd_en = 1'b1;
        cnt   = 0;
        while (!(data_part == 2'd2 && spi_sclk && !spi_ste) && cnt < 1000) begin
            @(negedge div_clk);
            cnt++;
        end
        checks++;
        if (cnt >= 1000) begin
            errors++;
            $display("FAIL reach_part2 got timeout exp SHIFT of part 2");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (spi_ste !== 1'b1 || spi_sclk !== 1'b0 || data_part !== 2'd0 || busy !== 1'b0 ||
            spi_mosi !== 1'b0 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL async_rst got ste=%b sclk=%b part=%0d busy=%b mosi=%b rx=%h",
                     spi_ste, spi_sclk, data_part, busy, spi_mosi, rx_data);
        end
        rd_en = 1'b0;
        repeat (2) @(negedge div_clk);
        rst   = 1'b0;
        dones = 0;
        repeat (200) begin
            @(negedge div_clk);
            if (spi_done) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_done_after_rst got dones=%0d busy=%b exp 0/0", dones, busy);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        tx_data  = 8'h00;
        spi_miso = 1'b0;
        @(negedge div_clk);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_drop_midframe();
        test_rst_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
